// File: rtl/bcd_countdown_mmss.sv
// MM:SS BCD countdown timer with preset load, start/stop control and a self-clearing alarm.
// Optional build macro BCD_COUNTDOWN_AUTORELOAD_EN restarts from the last preset on expiry.
module bcd_countdown_mmss #(
  parameter int ALARM_TICKS = 10
) (
  input  logic        CP,
  input  logic        CR,
  input  logic        EN,
  input  logic        LD,
  input  logic [15:0] LD_VAL,
  input  logic        START,
  input  logic        STOP,
  output logic [3:0]  MinH,
  output logic [3:0]  MinL,
  output logic [3:0]  SecH,
  output logic [3:0]  SecL,
  output logic        RUN,
  output logic        DONE,
  output logic        ALARM
);

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_PAUSE, ST_ALARM} state_t;

  localparam logic [7:0] ALARM_INIT = 8'(ALARM_TICKS);

  state_t     state_reg, state_next;
  // digit index 3..0 = MinH, MinL, SecH, SecL
  logic [3:0] digit_reg [4];
  logic [3:0] digit_next [4];
  logic [3:0] dec_digit [4];
  logic [3:0] ld_digit [4];
  logic [3:0] borrow;
  logic [7:0] alarm_cnt_reg, alarm_cnt_next;
  logic       done_reg, done_next;
  logic       count_zero, count_one;

`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
  logic [3:0] reload_reg [4];
  logic [3:0] reload_next [4];
  logic       reload_zero;
  assign reload_zero = (reload_reg[3] == 4'd0) && (reload_reg[2] == 4'd0) &&
                       (reload_reg[1] == 4'd0) && (reload_reg[0] == 4'd0);
`endif

  assign borrow[0] = 1'b1;

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_digit
      // SecH wraps/saturates at 5, every other digit at 9
      localparam logic [3:0] LIMIT = (gi == 1) ? 4'd5 : 4'd9;
      assign ld_digit[gi] = (LD_VAL[gi*4 +: 4] > LIMIT) ? LIMIT : LD_VAL[gi*4 +: 4];
      assign dec_digit[gi] = !borrow[gi]            ? digit_reg[gi] :
                             (digit_reg[gi] == 4'd0) ? LIMIT : digit_reg[gi] - 4'd1;
      if (gi < 3) begin : g_borrow
        assign borrow[gi+1] = borrow[gi] && (digit_reg[gi] == 4'd0);
      end
    end
  endgenerate

  assign count_zero = (digit_reg[3] == 4'd0) && (digit_reg[2] == 4'd0) &&
                      (digit_reg[1] == 4'd0) && (digit_reg[0] == 4'd0);
  assign count_one  = (digit_reg[3] == 4'd0) && (digit_reg[2] == 4'd0) &&
                      (digit_reg[1] == 4'd0) && (digit_reg[0] == 4'd1);

  always_ff @(posedge CP or posedge CR) begin
    if (CR) begin
      state_reg     <= ST_IDLE;
      alarm_cnt_reg <= 8'd0;
      done_reg      <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        digit_reg[i]  <= 4'd0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        reload_reg[i] <= 4'd0;
`endif
      end
    end else begin
      state_reg     <= state_next;
      alarm_cnt_reg <= alarm_cnt_next;
      done_reg      <= done_next;
      for (int i = 0; i < 4; i++) begin
        digit_reg[i]  <= digit_next[i];
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
        reload_reg[i] <= reload_next[i];
`endif
      end
    end
  end

  always_comb begin
    state_next     = state_reg;
    digit_next     = digit_reg;
    alarm_cnt_next = alarm_cnt_reg;
    done_next      = 1'b0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    reload_next    = reload_reg;
`endif
    if (LD && state_reg != ST_RUN) begin
      state_next     = ST_IDLE;
      digit_next     = ld_digit;
      alarm_cnt_next = 8'd0;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
      reload_next    = ld_digit;
`endif
    end else if (STOP) begin
      if (state_reg == ST_RUN) begin
        state_next = ST_PAUSE;
      end else if (state_reg == ST_ALARM) begin
        state_next     = ST_IDLE;
        alarm_cnt_next = 8'd0;
      end
    end else if (START) begin
      if ((state_reg == ST_IDLE || state_reg == ST_PAUSE) && !count_zero) begin
        state_next = ST_RUN;
      end else if (state_reg == ST_ALARM) begin
        state_next     = ST_IDLE;
        alarm_cnt_next = 8'd0;
      end
    end else if (EN && !LD) begin
      // an ignored LD during RUN still suppresses that cycle's decrement
      if (state_reg == ST_RUN) begin
        digit_next = dec_digit;
        if (count_one) begin
          done_next = 1'b1;
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
          if (!reload_zero) begin
            digit_next = reload_reg;
          end else begin
            state_next     = ST_ALARM;
            alarm_cnt_next = ALARM_INIT;
          end
`else
          state_next     = ST_ALARM;
          alarm_cnt_next = ALARM_INIT;
`endif
        end
      end else if (state_reg == ST_ALARM) begin
        if (alarm_cnt_reg <= 8'd1) begin
          state_next     = ST_IDLE;
          alarm_cnt_next = 8'd0;
        end else begin
          alarm_cnt_next = alarm_cnt_reg - 8'd1;
        end
      end
    end
  end

  always_comb begin
    MinH  = digit_reg[3];
    MinL  = digit_reg[2];
    SecH  = digit_reg[1];
    SecL  = digit_reg[0];
    RUN   = (state_reg == ST_RUN);
    ALARM = (state_reg == ST_ALARM);
    DONE  = done_reg;
  end

endmodule

// File: tb/tb_bcd_countdown_mmss.sv
// Directed self-checking bench for bcd_countdown_mmss (default build and autoreload build).
module tb_bcd_countdown_mmss;

  logic        CP = 1'b0;
  logic        CR = 1'b1;
  logic        EN = 1'b0;
  logic        LD = 1'b0;
  logic [15:0] LD_VAL = 16'h0000;
  logic        START = 1'b0;
  logic        STOP = 1'b0;
  logic [3:0]  MinH, MinL, SecH, SecL;
  logic        RUN, DONE, ALARM;
  logic [15:0] digits;

  int n_checks = 0;
  int n_fail = 0;

  assign digits = {MinH, MinL, SecH, SecL};

  bcd_countdown_mmss #(.ALARM_TICKS(10)) dut (
    .CP(CP), .CR(CR), .EN(EN), .LD(LD), .LD_VAL(LD_VAL),
    .START(START), .STOP(STOP),
    .MinH(MinH), .MinL(MinL), .SecH(SecH), .SecL(SecL),
    .RUN(RUN), .DONE(DONE), .ALARM(ALARM)
  );

  always #5 CP = ~CP;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  // one CP cycle with the given strobes; outputs are sampled 1 time unit after the edge
  task automatic step(input logic en, input logic ld, input logic start, input logic stop,
                      input logic [15:0] val);
    EN = en; LD = ld; START = start; STOP = stop; LD_VAL = val;
    @(posedge CP);
    #1;
    EN = 1'b0; LD = 1'b0; START = 1'b0; STOP = 1'b0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 1'b0, 16'h0000);
  endtask

  initial begin
    #12;
    check_eq("reset_digits", 32'(digits), 32'h0000);
    check_eq("reset_run", 32'(RUN), 32'd0);
    check_eq("reset_alarm", 32'(ALARM), 32'd0);
    @(posedge CP); #1;
    CR = 1'b0;

    // asynchronous clear in the middle of a run
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h1234);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("t1_run", 32'(RUN), 32'd1);
    check_eq("t1_digits", 32'(digits), 32'h1234);
    #2;
    CR = 1'b1;
    #1;
    check_eq("t1_cr_digits", 32'(digits), 32'h0000);
    check_eq("t1_cr_run", 32'(RUN), 32'd0);
    check_eq("t1_cr_done", 32'(DONE), 32'd0);
    check_eq("t1_cr_alarm", 32'(ALARM), 32'd0);
    @(posedge CP); #1;
    CR = 1'b0;

    // 01:00 countdown to expiry
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0100);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    ticks(1);
    check_eq("t2_tick1", 32'(digits), 32'h0059);
    ticks(58);
    check_eq("t2_tick59", 32'(digits), 32'h0001);
    check_eq("t2_done_pre", 32'(DONE), 32'd0);
    ticks(1);
    check_eq("t2_done", 32'(DONE), 32'd1);
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    check_eq("t2_reload_digits", 32'(digits), 32'h0100);
    check_eq("t2_reload_run", 32'(RUN), 32'd1);
    check_eq("t2_reload_alarm", 32'(ALARM), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("t2_done_width", 32'(DONE), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    check_eq("t2_stop_run", 32'(RUN), 32'd0);
`else
    check_eq("t2_exp_digits", 32'(digits), 32'h0000);
    check_eq("t2_alarm_on", 32'(ALARM), 32'd1);
    check_eq("t2_exp_run", 32'(RUN), 32'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0, 16'h0000);
    check_eq("t2_done_width", 32'(DONE), 32'd0);
    check_eq("t2_alarm_hold", 32'(ALARM), 32'd1);
    ticks(9);
    check_eq("t2_alarm_9", 32'(ALARM), 32'd1);
    ticks(1);
    check_eq("t2_alarm_10", 32'(ALARM), 32'd0);
    check_eq("t2_idle_digits", 32'(digits), 32'h0000);
    check_eq("t2_idle_run", 32'(RUN), 32'd0);
`endif

    // digit sanitising and long borrow
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'hFA7C);
    check_eq("t3_sanitised", 32'(digits), 32'h9959);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    ticks(1);
    check_eq("t3_tick1", 32'(digits), 32'h9958);
    ticks(59);
    check_eq("t3_tick60", 32'(digits), 32'h9859);

    // STOP together with a tick pauses without decrementing
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0005);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000);
    check_eq("t4_stop_digits", 32'(digits), 32'h0005);
    check_eq("t4_stop_run", 32'(RUN), 32'd0);
    ticks(3);
    check_eq("t4_pause_hold", 32'(digits), 32'h0005);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("t4_resume_run", 32'(RUN), 32'd1);
    ticks(1);
    check_eq("t4_resume_tick", 32'(digits), 32'h0004);

    // ignored strobes and START/STOP collision
    step(1'b0, 1'b0, 1'b0, 1'b1, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0000);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("t5_start_zero", 32'(RUN), 32'd0);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0010);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0030);
    check_eq("t5_ld_in_run", 32'(digits), 32'h0010);
    check_eq("t5_ld_run_state", 32'(RUN), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b1, 16'h0000);
    check_eq("t5_start_stop", 32'(RUN), 32'd0);
    ticks(1);
    check_eq("t5_paused", 32'(digits), 32'h0010);

    // short preset expiry
    step(1'b0, 1'b1, 1'b0, 1'b0, 16'h0003);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    ticks(3);
    check_eq("t6_done", 32'(DONE), 32'd1);
`ifdef BCD_COUNTDOWN_AUTORELOAD_EN
    check_eq("t6_digits", 32'(digits), 32'h0003);
    check_eq("t6_run", 32'(RUN), 32'd1);
    check_eq("t6_alarm", 32'(ALARM), 32'd0);
    ticks(1);
    check_eq("t6_done_low", 32'(DONE), 32'd0);
    check_eq("t6_after", 32'(digits), 32'h0002);
    ticks(2);
    check_eq("t6_done2", 32'(DONE), 32'd1);
    check_eq("t6_digits2", 32'(digits), 32'h0003);
`else
    check_eq("t6_digits", 32'(digits), 32'h0000);
    check_eq("t6_alarm", 32'(ALARM), 32'd1);
    step(1'b0, 1'b0, 1'b1, 1'b0, 16'h0000);
    check_eq("t6_start_clr", 32'(ALARM), 32'd0);
    check_eq("t6_start_run", 32'(RUN), 32'd0);
    check_eq("t6_start_digits", 32'(digits), 32'h0000);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
